// File: rtl/crash_course_io_host_bridge.sv
// Host-side end of the crash-course CPU 8-bit IO port: a TX queue presented on cpu_io_in and an RX change-capture queue.
// Optional sticky RX drop flag enabled by defining IO_HOST_OVERFLOW_FLAG_EN.
module crash_course_io_host_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       sync_rst,
  input  logic       clk_en,
  input  logic       system_enabled,
  output logic [7:0] cpu_io_in,
  input  logic [7:0] cpu_io_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } pres_state_e;

  logic cpu_tick;
  assign cpu_tick = clk_en & system_enabled;

  // ---------------- TX queue ----------------
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_ready_q, tx_ready_d;
  logic          tx_push, tx_pop;
  logic [7:0]    tx_head;

  pres_state_e   state_q;
  logic [HW-1:0] hold_cnt_q;
  logic [7:0]    cpu_io_in_q;

  assign tx_push = tx_valid & tx_ready_q;
  assign tx_head = tx_mem_q[tx_rd_q];
  // The presenter takes a byte whenever it is idle or finishing the last hold tick.
  assign tx_pop  = cpu_tick & (tx_cnt_q != CNT_ZERO) &
                   ((state_q == S_IDLE) | (hold_cnt_q == HOLD_ZERO));

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push) begin
      tx_wr_d = tx_wr_q + PTR_ONE;
    end else begin
      tx_wr_d = tx_wr_q;
    end
    if (tx_pop) begin
      tx_rd_d = tx_rd_q + PTR_ONE;
    end else begin
      tx_rd_d = tx_rd_q;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    tx_ready_d = (tx_cnt_d != DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wr_q] <= tx_data;
    end
  end

  // ---------------- Presenter FSM ----------------
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= HOLD_ZERO;
      cpu_io_in_q <= 8'h00;
    end else if (cpu_tick) begin
      case (state_q)
        S_IDLE: begin
          if (tx_pop) begin
            cpu_io_in_q <= tx_head;
            hold_cnt_q  <= HOLD_LAST;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q != HOLD_ZERO) begin
            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
          end else if (tx_pop) begin
            cpu_io_in_q <= tx_head;
            hold_cnt_q  <= HOLD_LAST;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          hold_cnt_q <= HOLD_ZERO;
        end
      endcase
    end
  end

  assign cpu_io_in = cpu_io_in_q;
  assign tx_ready  = tx_ready_q;

  // ---------------- RX change capture ----------------
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [7:0]    prev_out_q, prev_out_d;
  logic          rx_push_req, rx_push, rx_pop, rx_full;
  logic [7:0]    rx_head_next;

  assign rx_full     = (rx_cnt_q == DEPTH_C);
  assign rx_pop      = rx_valid_q & rx_ready;
  assign rx_push_req = cpu_tick & (cpu_io_out != prev_out_q);
  // A pop in the same cycle frees the slot the capture needs.
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);

  always_comb begin
    rx_wr_d    = rx_wr_q;
    rx_rd_d    = rx_rd_q;
    rx_cnt_d   = rx_cnt_q;
    prev_out_d = prev_out_q;
    if (cpu_tick) begin
      prev_out_d = cpu_io_out;
    end else begin
      prev_out_d = prev_out_q;
    end
    if (rx_push) begin
      rx_wr_d = rx_wr_q + PTR_ONE;
    end else begin
      rx_wr_d = rx_wr_q;
    end
    if (rx_pop) begin
      rx_rd_d = rx_rd_q + PTR_ONE;
    end else begin
      rx_rd_d = rx_rd_q;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    // The byte being written becomes the head when it lands on the next read slot.
    if (rx_push && (rx_wr_q == rx_rd_d)) begin
      rx_head_next = cpu_io_out;
    end else begin
      rx_head_next = rx_mem_q[rx_rd_d];
    end
    rx_valid_d = (rx_cnt_d != CNT_ZERO);
    if (rx_valid_d) begin
      rx_data_d = rx_head_next;
    end else begin
      rx_data_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      prev_out_q <= 8'h00;
    end else begin
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      prev_out_q <= prev_out_d;
    end
  end

  // RX storage write port.
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem_q[rx_wr_q] <= cpu_io_out;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef IO_HOST_OVERFLOW_FLAG_EN
  logic rx_drop;
  logic overflow_q, overflow_d;

  assign rx_drop = rx_push_req & rx_full & ~rx_pop;

  always_comb begin
    overflow_d = overflow_q | rx_drop;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_crash_course_io_host_bridge.sv
// Randomized bench for crash_course_io_host_bridge against a queue-based reference model.
module tb_crash_course_io_host_bridge;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       sync_rst, clk_en, system_enabled;
  logic [7:0] cpu_io_in, cpu_io_out, tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, overflow;

  crash_course_io_host_bridge #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .system_enabled(system_enabled),
    .cpu_io_in(cpu_io_in), .cpu_io_out(cpu_io_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queues plus "ticks left on the current byte".
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         ticks_left;
  logic [7:0] m_io_in, m_prev;
  bit         m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit tv, input logic [7:0] td,
                            input logic [7:0] co, input bit rr);
    bit accept_tx, accept_rx_pop;
    if (rst) begin
      txq.delete(); rxq.delete();
      ticks_left = 0; m_io_in = 8'h00; m_prev = 8'h00; m_ovf = 1'b0;
      return;
    end
    accept_tx     = tv && (txq.size() < DEPTH);
    accept_rx_pop = rr && (rxq.size() > 0);
    if (tick) begin
      if (ticks_left > 0) ticks_left--;
      if (ticks_left == 0 && txq.size() > 0) begin
        m_io_in    = txq.pop_front();
        ticks_left = HOLD;
      end
    end
    if (accept_tx) txq.push_back(td);
    if (accept_rx_pop) void'(rxq.pop_front());
    if (tick) begin
      if (co != m_prev) begin
        if (rxq.size() < DEPTH) rxq.push_back(co);
        else m_ovf = 1'b1;
      end
      m_prev = co;
    end
  endtask

  task automatic step(input bit rst, input bit ce, input bit se, input bit tv,
                      input logic [7:0] td, input logic [7:0] co, input bit rr);
    sync_rst = rst; clk_en = ce; system_enabled = se;
    tx_valid = tv; tx_data = td; cpu_io_out = co; rx_ready = rr;
    model_step(rst, ce && se, tv, td, co, rr);
    @(posedge clk);
    #1;
    check_eq("cpu_io_in", {24'h0, cpu_io_in}, {24'h0, m_io_in});
    check_eq("tx_ready", {31'h0, tx_ready}, {31'h0, (txq.size() < DEPTH)});
    check_eq("rx_valid", {31'h0, rx_valid}, {31'h0, (rxq.size() > 0)});
    if (rxq.size() > 0) check_eq("rx_data", {24'h0, rx_data}, {24'h0, rxq[0]});
    else if (rst) check_eq("rx_data_rst", {24'h0, rx_data}, 32'h0);
`ifdef IO_HOST_OVERFLOW_FLAG_EN
    check_eq("overflow", {31'h0, overflow}, {31'h0, m_ovf});
`else
    check_eq("overflow", {31'h0, overflow}, 32'h0);
`endif
  endtask

  initial begin
    logic [7:0] co;
    logic [7:0] seq [5];
    bit ce, se, tv, rr, rst;
    seq[0] = 8'h00; seq[1] = 8'h05; seq[2] = 8'h05; seq[3] = 8'h07; seq[4] = 8'h00;

    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Single byte, then back-to-back bytes.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Hold stretched by toggling clk_en, and no action while the system is disabled.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h5C, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h6D, 8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0);

    // RX change capture, fill, drop, then pop-and-push while full.
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, seq[i], 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1);

    // Reset mid-hold with bytes still queued.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h42, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 8'h42, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h42, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 8'h43, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random traffic.
    co = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      se  = ($urandom_range(0, 7) != 0);
      tv  = ($urandom_range(0, 9) < 4);
      rr  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 9) < 3) co = 8'(8'h11 * $urandom_range(0, 3));
      step(rst, ce, se, tv, 8'($urandom), co, rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
